// File: rtl/alu_if.sv
// ALU operand/result bundle: operation select, two operands, the
// combinational result and its zero flag.
interface alu_intf #(
  parameter int WIDTH = 32
);
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] result;
  logic             zero;

  // The requester drives the operation and operands and observes the outcome.
  modport master (
    output alu_op,
    output in_a,
    output in_b,
    input  result,
    input  zero
  );

  // The ALU consumes the operation and operands and produces the outcome.
  modport slave (
    input  alu_op,
    input  in_a,
    input  in_b,
    output result,
    output zero
  );
endinterface : alu_intf

// File: rtl/alu.sv
// Integer ALU: a combinational result/zero/op_invalid path with zero latency,
// plus a registered copy of all three flags with one cycle of latency.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_intf.slave           bus,
  output logic             op_invalid,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             op_invalid_q
);

  // Only the low log2(WIDTH) bits of in_b select a shift distance.
  localparam int SHAMT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  logic [WIDTH-1:0]   result_d;
  logic               zero_d;
  logic               op_invalid_d;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = bus.in_b[SHAMT_W-1:0];

  // Decode the operation and compute the combinational result.
  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    result_d     = '0;
    op_invalid_d = 1'b0;
    case (alu_op_e'(bus.alu_op))
      OP_AND:  result_d = bus.in_a & bus.in_b;
      OP_OR:   result_d = bus.in_a | bus.in_b;
      OP_ADD:  result_d = bus.in_a + bus.in_b;
      OP_XOR:  result_d = bus.in_a ^ bus.in_b;
      OP_SLL:  result_d = bus.in_a << shamt;
      OP_SRL:  result_d = bus.in_a >> shamt;
      OP_SUB:  result_d = bus.in_a - bus.in_b;
      OP_SRA:  result_d = $signed(bus.in_a) >>> shamt;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
      // Undefined encodings yield a zero result and raise op_invalid.
      default: begin
        result_d     = '0;
        op_invalid_d = 1'b1;
      end
    endcase
  end

  // Zero flag follows the wrapped result for every operation.
  assign zero_d     = (result_d == '0);
  assign bus.result = result_d;
  assign bus.zero   = zero_d;
  assign op_invalid = op_invalid_d;

  // Register the combinational outputs; reset forces the idle value pattern.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input before any of them update on the same edge.
    if (rst) begin
      result_q     <= '0;
      zero_q       <= 1'b1;
      op_invalid_q <= 1'b0;
    end else begin
      result_q     <= result_d;
      zero_q       <= zero_d;
      op_invalid_q <= op_invalid_d;
    end
  end

endmodule : alu

// File: tb/tb_alu.sv
// Directed and random self-checking bench for the ALU: combinational path,
// registered path, asynchronous reset behaviour and a reference-model sweep.
module tb_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             op_invalid;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             op_invalid_q;

  int checks   = 0;
  int failures = 0;

  alu_intf #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .op_invalid   (op_invalid),
    .result_q     (result_q),
    .zero_q       (zero_q),
    .op_invalid_q (op_invalid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operation and operands, then let the combinational path settle.
  task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.alu_op = op;
    bus.in_a   = a;
    bus.in_b   = b;
    #1;
  endtask

  // Check the combinational trio {result, zero, op_invalid}.
  task automatic check_comb(input string tag, input logic [WIDTH-1:0] exp_res, input logic exp_inv);
    check(tag, {30'd0, bus.result, bus.zero, op_invalid},
               {30'd0, exp_res, (exp_res == '0), exp_inv});
  endtask

  // Check the registered trio {result_q, zero_q, op_invalid_q}.
  task automatic check_reg(input string tag, input logic [WIDTH-1:0] exp_res,
                           input logic exp_zero, input logic exp_inv);
    check(tag, {30'd0, result_q, zero_q, op_invalid_q},
               {30'd0, exp_res, exp_zero, exp_inv});
  endtask

  // Independent reference: returns {result, op_invalid}.
  function automatic logic [WIDTH:0] model(input logic [3:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    int s;
    ones = '1;
    s = int'(b[4:0]);
    r = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a ^ b;
      4'd4: r = a << s;
      4'd5: r = a >> s;
      4'd6: r = a + ~b + 1;
      4'd7: r = (a >> s) | (a[WIDTH-1] ? ~(ones >> s) : '0);
      4'd8: r = (a[WIDTH-1] != b[WIDTH-1]) ? {31'd0, a[WIDTH-1]} : {31'd0, (a < b)};
      4'd9: r = {31'd0, (a < b)};
      default: return {{WIDTH{1'b0}}, 1'b1};
    endcase
    return {r, 1'b0};
  endfunction

  initial begin
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst = 1'b1;
    drive(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    // Reset state of the registers, and combinational path unaffected by reset.
    check_reg("reset_regs", 32'h0, 1'b1, 1'b0);
    check_comb("and_during_reset", 32'h00F0_00F0, 1'b0);
    @(posedge clk); #1;
    check_reg("reset_holds_over_edge", 32'h0, 1'b1, 1'b0);

    // First edge after reset release captures normally.
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0001, 32'h0000_0001, 32'h0000_0002);
    check_comb("or_comb", 32'h0000_0003, 1'b0);
    @(posedge clk); #1;
    check_reg("or_registered", 32'h0000_0003, 1'b0, 1'b0);

    // Mid-cycle reset clears the registers without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_reg("async_reset_midcycle", 32'h0, 1'b1, 1'b0);
    drive(4'b0011, 32'h1234_0000, 32'h0000_5678);
    @(posedge clk); #1;
    check_reg("reset_overrides_capture", 32'h0, 1'b1, 1'b0);

    // Registered invalid op after release.
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1100, 32'hDEAD_BEEF, 32'h1111_1111);
    @(posedge clk); #1;
    check_reg("invalid_registered", 32'h0, 1'b1, 1'b1);

    // Directed combinational vectors with hand-computed results.
    drive(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0); check_comb("and",          32'h00F0_00F0, 1'b0);
    drive(4'b0001, 32'h0000_0000, 32'h0000_0000); check_comb("or_zero",      32'h0000_0000, 1'b0);
    drive(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001); check_comb("add_wrap",     32'h0000_0000, 1'b0);
    drive(4'b0010, 32'h0000_0005, 32'h0000_0007); check_comb("add",          32'h0000_000C, 1'b0);
    drive(4'b0011, 32'hAAAA_5555, 32'hFFFF_0000); check_comb("xor",          32'h5555_5555, 1'b0);
    drive(4'b0100, 32'h0000_0003, 32'hFFFF_FFE1); check_comb("sll_upper_ign",32'h0000_0006, 1'b0);
    drive(4'b0100, 32'h0000_0001, 32'h0000_001F); check_comb("sll_31",       32'h8000_0000, 1'b0);
    drive(4'b0101, 32'h8000_0000, 32'h0000_0024); check_comb("srl_upper_ign",32'h0800_0000, 1'b0);
    drive(4'b0110, 32'h0000_0005, 32'h0000_0007); check_comb("sub_neg",      32'hFFFF_FFFE, 1'b0);
    drive(4'b0110, 32'h1234_5678, 32'h1234_5678); check_comb("sub_equal",    32'h0000_0000, 1'b0);
    drive(4'b0110, 32'h0000_0000, 32'h0000_0001); check_comb("sub_borrow",   32'hFFFF_FFFF, 1'b0);
    drive(4'b0111, 32'h8000_0000, 32'h0000_0004); check_comb("sra_neg",      32'hF800_0000, 1'b0);
    drive(4'b0111, 32'h7000_0000, 32'h0000_0004); check_comb("sra_pos",      32'h0700_0000, 1'b0);
    drive(4'b1000, 32'h8000_0000, 32'h0000_0001); check_comb("slt_neg",      32'h0000_0001, 1'b0);
    drive(4'b1001, 32'h8000_0000, 32'h0000_0001); check_comb("sltu_big",     32'h0000_0000, 1'b0);
    drive(4'b1000, 32'h0000_0001, 32'hFFFF_FFFF); check_comb("slt_pos_vs_neg",32'h0000_0000, 1'b0);
    drive(4'b1001, 32'h0000_0001, 32'hFFFF_FFFF); check_comb("sltu_small",   32'h0000_0001, 1'b0);
    drive(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF); check_comb("invalid_1010", 32'h0000_0000, 1'b1);
    drive(4'b1100, 32'h1234_5678, 32'h8765_4321); check_comb("invalid_1100", 32'h0000_0000, 1'b1);
    drive(4'b1111, 32'h0000_0001, 32'h0000_0002); check_comb("invalid_1111", 32'h0000_0000, 1'b1);

    // Random sweep of every defined op against the reference model.
    for (int op = 0; op < 10; op++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom;
        rb = (n % 8 == 0) ? ra : $urandom;
        if (n % 16 == 1) rb = {27'd0, 5'($urandom_range(31))};
        drive(4'(op), ra, rb);
        m = model(4'(op), ra, rb);
        check_comb($sformatf("rand_op%0d_a%h_b%h", op, ra, rb), m[WIDTH:1], m[0]);
      end
    end

    // Random operands on every undefined encoding.
    for (int op = 10; op < 16; op++) begin
      for (int n = 0; n < 20; n++) begin
        ra = $urandom;
        rb = $urandom;
        drive(4'(op), ra, rb);
        check_comb($sformatf("rand_invalid_op%0d", op), 32'h0, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu
